// File: rtl/ysyx_23060201_isram_pkg.sv
// Shared constants, response codes, FSM encoding and LFSR step for the
// instruction-memory responder.
package ysyx_23060201_isram_pkg;

   localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
   localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      state_e     state;
      logic [7:0] lfsr;
   } dbg_t;

   // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

endpackage

// File: rtl/ysyx_23060201_isram_if.sv
// Fetch-side read bus (AR/R) plus the physical-memory read port of the responder.
interface ysyx_23060201_isram_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Handshake rule: a beat transfers on a rising clock edge where valid and
   // ready are both high; valid and its payload stay stable until that edge,
   // and ready never depends combinationally on valid.
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   // Memory read port: each cycle pmem_en is high is one pmem_read call, and
   // the memory answers on pmem_rdata combinationally in that same cycle.
   logic                  pmem_en;
   logic [ADDR_WIDTH-1:0] pmem_addr;
   logic [3:0]            pmem_mask;
   logic [DATA_WIDTH-1:0] pmem_rdata;

   modport master (
      output arvalid, araddr, rready,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      input  arvalid, araddr, rready, pmem_rdata,
      output arready, rvalid, rdata, rresp, pmem_en, pmem_addr, pmem_mask
   );

   modport mem (
      input  pmem_en, pmem_addr, pmem_mask,
      output pmem_rdata
   );
endinterface

// File: rtl/ysyx_23060201_lfsr8.sv
// 8-bit free-running Fibonacci LFSR used to jitter the access latency.
module ysyx_23060201_lfsr8
   import ysyx_23060201_isram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) q <= seed;
      else        q <= lfsr8_next(q);
   end

endmodule

// File: rtl/ysyx_23060201_isram.sv
// Instruction-memory responder: one outstanding AR request, fixed plus optional
// LFSR-driven latency, address classification, then a held R response.
module ysyx_23060201_isram
   import ysyx_23060201_isram_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] MBASE      = PMEM_BASE,
   parameter logic [ADDR_WIDTH-1:0] MSIZE      = PMEM_SIZE,
   parameter int                    LATENCY    = 1,
   parameter int                    RAND_DELAY = 0,
   parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ysyx_23060201_isram_if.slave  bus,
   output dbg_t                  dbg
);

   localparam int                    CNT_W    = 16;
   localparam logic [CNT_W-1:0]      CNT_BASE = CNT_W'(LATENCY - 1);
   // Range bounds one bit wider than the address so MBASE+MSIZE cannot wrap.
   localparam logic [ADDR_WIDTH:0]   LO_EXT   = {1'b0, MBASE};
   localparam logic [ADDR_WIDTH:0]   HI_EXT   = {1'b0, MBASE} + {1'b0, MSIZE};

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_extra;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   resp_e                 rresp_q, rresp_d;
   resp_e                 cls;
   logic [7:0]            lfsr;

   function automatic resp_e classify(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH:0] ae;
      ae = {1'b0, a};
      if (ae < LO_EXT || ae >= HI_EXT) return RESP_DECERR;
      if (a[1:0] != 2'b00)             return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   ysyx_23060201_lfsr8 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (LFSR_SEED),
      .q     (lfsr)
   );

   always_comb begin
      cls       = classify(addr_q);
      cnt_extra = (RAND_DELAY != 0) ? {{(CNT_W-2){1'b0}}, lfsr[1:0]} : '0;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      bus.arready = 1'b0;
      bus.pmem_en = 1'b0;
      case (state_q)
         IDLE: begin
            bus.arready = 1'b1;
            if (bus.arvalid) begin
               addr_d  = bus.araddr;
               cnt_d   = CNT_BASE + cnt_extra;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rvalid_d = 1'b1;
               rresp_d  = cls;
               rdata_d  = '0;
               // Memory is only touched for in-range aligned requests, never in reset.
               if (cls == RESP_OKAY) begin
                  bus.pmem_en = rst_n;
                  rdata_d     = bus.pmem_rdata;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.rresp     = rresp_q;
   assign bus.pmem_addr = addr_q;
   assign bus.pmem_mask = 4'b1111;

   assign dbg.state = state_q;
   assign dbg.lfsr  = lfsr;

endmodule
